// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: latches operands, pulses the multiplier/divider start,
// waits for the unit's ready and steers its HI/LO pair onto the register
// write port. Raises divide-by-zero and, optionally, wait-timeout exceptions.
// Optional feature macro: MULDIV_TIMEOUT_EN (wait timeout counter + TOUT).
//
// state    | meaning
// IDLE     | waiting for mult_req / div_req
// LAUNCH_M | one-cycle mult_start pulse
// WAIT_M   | waiting for mult_ready
// LAUNCH_D | one-cycle div_start pulse
// WAIT_D   | waiting for div_ready / div_zero_in
// COMMIT   | HI/LO write and done pulse
// DZERO    | divide-by-zero exception pulse
// TOUT     | timeout exception pulse (timeout build only)
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_req,
  input  logic        div_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_ready,
  input  logic        div_ready,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_zero_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        hi_wr,
  output logic        lo_wr,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout_exc
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH_M = 3'd1,
    WAIT_M   = 3'd2,
    LAUNCH_D = 3'd3,
    WAIT_D   = 3'd4,
    COMMIT   = 3'd5,
    DZERO    = 3'd6
`ifdef MULDIV_TIMEOUT_EN
    , TOUT   = 3'd7
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ua_q, ua_d;
  logic [31:0] ub_q, ub_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d = state_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (mult_req) begin
          ua_d    = op_a;
          ub_d    = op_b;
          state_d = LAUNCH_M;
        end else if (div_req) begin
          if (op_b == 32'd0) begin
            state_d = DZERO;
          end else begin
            ua_d    = op_a;
            ub_d    = op_b;
            state_d = LAUNCH_D;
          end
        end
      end
      LAUNCH_M: begin
        state_d = WAIT_M;
`ifdef MULDIV_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      LAUNCH_D: begin
        state_d = WAIT_D;
`ifdef MULDIV_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      WAIT_M: begin
`ifdef MULDIV_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (mult_ready) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          state_d = COMMIT;
        end
`ifdef MULDIV_TIMEOUT_EN
        else if (cnt_d == TO_LIMIT) begin
          state_d = TOUT;
        end
`endif
      end
      WAIT_D: begin
`ifdef MULDIV_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (div_zero_in) begin
          state_d = DZERO;
        end else if (div_ready) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          state_d = COMMIT;
        end
`ifdef MULDIV_TIMEOUT_EN
        else if (cnt_d == TO_LIMIT) begin
          state_d = TOUT;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ua_q    <= 32'd0;
      ub_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign unit_a       = ua_q;
  assign unit_b       = ub_q;
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign mult_start   = (state_q == LAUNCH_M);
  assign div_start    = (state_q == LAUNCH_D);
  assign hi_wr        = (state_q == COMMIT);
  assign lo_wr        = (state_q == COMMIT);
  assign done         = (state_q == COMMIT);
  assign div_zero_exc = (state_q == DZERO);
  assign busy         = (state_q != IDLE);
`ifdef MULDIV_TIMEOUT_EN
  assign timeout_exc  = (state_q == TOUT);
`else
  assign timeout_exc  = 1'b0;
`endif

endmodule
